// File: rtl/jtpang_pkg.sv
// Shared definitions for the jtpang SDRAM bank arbiter: FSM encoding,
// bank address width, slot limit and the bank address helper.
package jtpang_pkg;

    localparam int BA_AW     = 22;
    localparam int SLOTS_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    // Slot word address relocated into the bank; wraps modulo 2^BA_AW.
    function automatic logic [BA_AW-1:0] bank_addr(input logic [BA_AW-1:0] off,
                                                   input logic [BA_AW-1:0] addr);
        return off + addr;
    endfunction

endpackage

// File: rtl/jtpang_bank_arb_if.sv
// Slot request bus plus one SDRAM bank channel; the arbiter uses the slave
// modport, the ROM consumers / controller side uses master.
interface jtpang_bank_arb_if
    import jtpang_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22
);
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*32-1:0] slot_data;
    logic [BA_AW-1:0]    ba_addr;
    logic                ba_rd;
    logic                ba_ack;
    logic                ba_dst;
    logic                ba_dok;
    logic                ba_rdy;
    logic [15:0]         data_read;

    modport slave (
        input  slot_cs, slot_addr, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
        output slot_ok, slot_data, ba_addr, ba_rd
    );

    modport master (
        output slot_cs, slot_addr, ba_ack, ba_dst, ba_dok, ba_rdy, data_read,
        input  slot_ok, slot_data, ba_addr, ba_rd
    );
endinterface

// File: rtl/jtpang_arb_pick.sv
// Combinational winner select: lowest pending index, or a round-robin
// search starting one past the last winner.
module jtpang_arb_pick #(
    parameter int SLOTS = 4,
    parameter int SW    = 2
) (
    input  logic [SLOTS-1:0] pend,
    input  logic [SW-1:0]    ptr,
    input  logic             rr,
    output logic [SLOTS-1:0] win_oh,
    output logic [SW-1:0]    win_idx,
    output logic             win_any
);
    logic [SW:0] j_s;

    // Winner search; later loop iterations override earlier ones, so the
    // iteration order runs from lowest priority to highest.
    always_comb begin
        win_idx = '0;
        win_any = |pend;
        j_s     = '0;
        if (rr) begin
            for (int k = SLOTS; k >= 1; k--) begin
                j_s     = {1'b0, ptr} + (SW+1)'(k);
                j_s     = (j_s >= (SW+1)'(SLOTS)) ? j_s - (SW+1)'(SLOTS) : j_s;
                win_idx = pend[j_s[SW-1:0]] ? j_s[SW-1:0] : win_idx;
            end
        end else begin
            for (int i = SLOTS - 1; i >= 0; i--) begin
                win_idx = pend[i] ? SW'(i) : win_idx;
            end
        end
    end

    // One-hot form of the selected index
    always_comb begin
        win_oh = '0;
        for (int i = 0; i < SLOTS; i++) begin
            win_oh[i] = win_any & (win_idx == SW'(i));
        end
    end

endmodule

// File: rtl/jtpang_bank_arb.sv
// Read arbiter multiplexing up to eight cached ROM slots onto one SDRAM bank.
module jtpang_bank_arb
    import jtpang_pkg::*;
#(
    parameter int                     SLOTS  = 4,
    parameter int                     AW     = 22,
    parameter logic [SLOTS-1:0]       DW32   = '0,
    parameter logic [SLOTS*BA_AW-1:0] OFFSET = '0,
    parameter int                     RR     = 0
) (
    input  logic               clk,
    input  logic               rst,
    jtpang_bank_arb_if.slave   bus
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    state_t           state_q, state_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [AW-1:0]    lat_q, lat_d;
    logic             ba_rd_q, ba_rd_d;
    logic [BA_AW-1:0] ba_addr_q, ba_addr_d;
    logic [1:0]       beat_q, beat_d;
    logic [31:0]      buf_q, buf_d;
    logic [AW-1:0]    tag_q [SLOTS];
    logic [AW-1:0]    tag_d [SLOTS];
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [31:0]      data_q [SLOTS];
    logic [31:0]      data_d [SLOTS];

    logic [AW-1:0]    addr_s [SLOTS];
    logic [BA_AW-1:0] off_s  [SLOTS];
    logic [SLOTS-1:0] hit_s, pend_s, win_oh_s;
    logic [SW-1:0]    win_idx_s;
    logic             win_any_s;
    logic             unused_s;

    assign unused_s = bus.ba_dst;

    // Slot address unpack and cache hit / pending detection
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_s[i] = bus.slot_addr[i*AW +: AW];
            off_s[i]  = OFFSET[i*BA_AW +: BA_AW];
            hit_s[i]  = bus.slot_cs[i] & valid_q[i] & (tag_q[i] == addr_s[i]);
        end
        pend_s = bus.slot_cs & ~hit_s;
    end

    jtpang_arb_pick #(
        .SLOTS (SLOTS),
        .SW    (SW)
    ) u_pick (
        .pend    (pend_s),
        .ptr     (ptr_q),
        .rr      (RR != 0),
        .win_oh  (win_oh_s),
        .win_idx (win_idx_s),
        .win_any (win_any_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bank request and cache update. Beats collect in buf so a
    // partially filled line is never visible through slot_data.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        lat_d     = lat_q;
        ba_rd_d   = ba_rd_q;
        ba_addr_d = ba_addr_q;
        beat_d    = beat_q;
        buf_d     = buf_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (win_any_s) begin
                    sel_d     = win_idx_s;
                    ptr_d     = win_idx_s;
                    lat_d     = '0;
                    ba_addr_d = '0;
                    for (int i = 0; i < SLOTS; i++) begin
                        lat_d     = lat_d | (addr_s[i] & {AW{win_oh_s[i]}});
                        ba_addr_d = ba_addr_d |
                                    (bank_addr(off_s[i], BA_AW'(addr_s[i])) & {BA_AW{win_oh_s[i]}});
                    end
                    ba_rd_d = 1'b1;
                    beat_d  = 2'd0;
                    buf_d   = 32'd0;
                    state_d = ST_WAIT;
                end else begin
                    ba_rd_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (bus.ba_ack) begin
                    ba_rd_d = 1'b0;
                    state_d = ST_XFER;
                end else begin
                    ba_rd_d = 1'b1;
                end
            end
            ST_XFER: begin
                ba_rd_d = 1'b0;
                if (bus.ba_dok) begin
                    if (beat_q == 2'd0) begin
                        buf_d[15:0] = bus.data_read;
                    end else if (beat_q == 2'd1 && DW32[sel_q]) begin
                        buf_d[31:16] = bus.data_read;
                    end else begin
                        buf_d = buf_q;
                    end
                    beat_d = (beat_q == 2'd2) ? 2'd2 : beat_q + 2'd1;
                end else begin
                    beat_d = beat_q;
                end
                if (bus.ba_rdy) begin
                    tag_d[sel_q]   = lat_q;
                    valid_d[sel_q] = 1'b1;
                    data_d[sel_q]  = buf_d;
                    beat_d         = 2'd0;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            default: begin
                ba_rd_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and cache registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            ptr_q     <= '0;
            lat_q     <= '0;
            ba_rd_q   <= 1'b0;
            ba_addr_q <= '0;
            beat_q    <= 2'd0;
            buf_q     <= 32'd0;
            valid_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= 32'd0;
            end
        end else begin
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            lat_q     <= lat_d;
            ba_rd_q   <= ba_rd_d;
            ba_addr_q <= ba_addr_d;
            beat_q    <= beat_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    // Outputs: hit flags, cached data and the registered bank request
    always_comb begin
        bus.slot_ok = hit_s;
        for (int i = 0; i < SLOTS; i++) begin
            bus.slot_data[i*32 +: 32] = data_q[i];
        end
        bus.ba_rd   = ba_rd_q;
        bus.ba_addr = ba_addr_q;
    end

endmodule

// File: tb/tb_jtpang_bank_arb.sv
// Directed bench: a fixed-priority and a round-robin arbiter driven in
// lockstep by the same slot and controller stimulus.
module tb_jtpang_bank_arb;
    localparam logic [87:0] OFFS = {22'h200000, 22'h080000, 22'h000100, 22'h000000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  cs = 4'd0;
    logic [87:0] addr_v = 88'd0;
    logic        ack = 1'b0, dst = 1'b0, dok = 1'b0, rdy = 1'b0;
    logic [15:0] dread = 16'd0;

    int n_chk = 0;
    int n_pass = 0;
    int rd_cnt = 0;
    logic rd_prev = 1'b0;
    int snap;

    logic [21:0] exp0 [4] = '{22'h000020, 22'h000130, 22'h080040, 22'h200050};
    logic [21:0] exp1 [4] = '{22'h080040, 22'h200050, 22'h000020, 22'h000130};

    jtpang_bank_arb_if #(.SLOTS(4), .AW(22)) if0 ();
    jtpang_bank_arb_if #(.SLOTS(4), .AW(22)) if1 ();

    assign if0.slot_cs = cs;  assign if0.slot_addr = addr_v;
    assign if0.ba_ack = ack;  assign if0.ba_dst = dst;  assign if0.ba_dok = dok;
    assign if0.ba_rdy = rdy;  assign if0.data_read = dread;
    assign if1.slot_cs = cs;  assign if1.slot_addr = addr_v;
    assign if1.ba_ack = ack;  assign if1.ba_dst = dst;  assign if1.ba_dok = dok;
    assign if1.ba_rdy = rdy;  assign if1.data_read = dread;

    jtpang_bank_arb #(.SLOTS(4), .AW(22), .DW32(4'b0001), .OFFSET(OFFS), .RR(0)) dut0 (
        .clk (clk), .rst (rst), .bus (if0.slave));
    jtpang_bank_arb #(.SLOTS(4), .AW(22), .DW32(4'b0001), .OFFSET(OFFS), .RR(1)) dut1 (
        .clk (clk), .rst (rst), .bus (if1.slave));

    always #5 clk = ~clk;

    // Rising edges of the fixed-priority bank request
    always @(posedge clk) begin
        rd_prev <= if0.ba_rd;
        if (if0.ba_rd && !rd_prev) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input string tag);
        int n;
        n = 0;
        while (!if0.ba_rd && n < 20) begin
            tick();
            n++;
        end
        chk(tag, if0.ba_rd, 1);
    endtask

    task automatic serve(input int nb, input logic [15:0] b0, input logic [15:0] b1);
        logic [21:0] a;
        a = if0.ba_addr;
        ack = 1'b1; tick(); ack = 1'b0;
        chk("rd_drop_after_ack", if0.ba_rd, 0);
        for (int k = 0; k < nb; k++) begin
            dok = 1'b1; dread = (k == 0) ? b0 : b1; tick(); dok = 1'b0;
        end
        chk("addr_stable", if0.ba_addr, a);
        rdy = 1'b1; tick(); rdy = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_ba_rd", if0.ba_rd, 0);
        chk("rst_ba_addr", if0.ba_addr, 0);
        chk("rst_slot_data", if0.slot_data, 0);

        // single-slot miss on slot 2
        cs = 4'b0100; addr_v[44 +: 22] = 22'h001234;
        #1;
        chk("miss_ok_low", if0.slot_ok[2], 0);
        chk("miss_no_rd_yet", if0.ba_rd, 0);
        tick();
        chk("miss_rd", if0.ba_rd, 1);
        chk("miss_addr", if0.ba_addr, 22'h081234);
        serve(1, 16'hBEEF, 16'h0000);
        chk("fill_ok2", if0.slot_ok[2], 1);
        chk("fill_data2", if0.slot_data[95:64], 32'h0000BEEF);

        // cache hit: no bank traffic, immediate ok on re-presentation
        snap = rd_cnt;
        for (int k = 0; k < 100; k++) tick();
        chk("hit_no_rd", rd_cnt - snap, 0);
        cs = 4'b0000; tick(); cs = 4'b0100; #1;
        chk("hit_ok_same_cycle", if0.slot_ok[2], 1);

        // 32-bit slot 0
        snap = rd_cnt;
        cs = 4'b0001; addr_v[0 +: 22] = 22'h000010;
        tick();
        chk("dw32_rd", if0.ba_rd, 1);
        chk("dw32_addr", if0.ba_addr, 22'h000010);
        serve(2, 16'h1111, 16'h2222);
        for (int k = 0; k < 20; k++) tick();
        chk("dw32_one_req", rd_cnt - snap, 1);
        chk("dw32_ok", if0.slot_ok[0], 1);
        chk("dw32_data", if0.slot_data[31:0], 32'h22221111);

        // address change on slot 1 during the transfer
        cs = 4'b0010; addr_v[22 +: 22] = 22'd5;
        tick();
        chk("chg_addr5", if0.ba_addr, 22'h000105);
        ack = 1'b1; tick(); ack = 1'b0;
        addr_v[22 +: 22] = 22'd6;
        dok = 1'b1; dread = 16'h5555; tick(); dok = 1'b0;
        rdy = 1'b1; tick(); rdy = 1'b0;
        #1;
        chk("chg_ok_low", if0.slot_ok[1], 0);
        tick();
        chk("chg_rerd", if0.ba_rd, 1);
        chk("chg_addr6", if0.ba_addr, 22'h000106);
        addr_v[22 +: 22] = 22'd5;
        #1;
        chk("chg_tag5_ok", if0.slot_ok[1], 1);
        chk("chg_tag5_data", if0.slot_data[63:32], 32'h00005555);
        addr_v[22 +: 22] = 22'd6;
        serve(1, 16'h6666, 16'h0000);
        chk("chg_ok6", if0.slot_ok[1], 1);
        chk("chg_data6", if0.slot_data[63:32], 32'h00006666);

        // all four slots miss together
        addr_v = {22'h000050, 22'h000040, 22'h000030, 22'h000020};
        cs = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            wait_rd("arb_wait");
            chk("arb_fixed_addr", if0.ba_addr, exp0[g]);
            chk("arb_rr_addr", if1.ba_addr, exp1[g]);
            serve(2, 16'hA000 + 16'(g), 16'hB000 + 16'(g));
        end
        chk("arb_fixed_all_ok", if0.slot_ok, 4'b1111);
        chk("arb_rr_all_ok", if1.slot_ok, 4'b1111);
        chk("arb_fixed_s0", if0.slot_data[31:0], 32'hB000A000);
        chk("arb_fixed_s3_extra_beat", if0.slot_data[127:96], 32'h0000A003);
        chk("arb_rr_s0", if1.slot_data[31:0], 32'hB002A002);
        chk("arb_rr_s2", if1.slot_data[95:64], 32'h0000A000);

        // reset while waiting for ack
        addr_v[0 +: 22] = 22'h000099;
        wait_rd("rst_wait");
        rst = 1'b1; tick();
        chk("rstw_rd0", if0.ba_rd, 0);
        chk("rstw_rd1", if1.ba_rd, 0);
        chk("rstw_addr", if0.ba_addr, 0);
        chk("rstw_ok0", if0.slot_ok, 0);
        chk("rstw_ok1", if1.slot_ok, 0);
        rst = 1'b0; cs = 4'b0000;
        tick();
        ack = 1'b1; dok = 1'b1; dread = 16'hDEAD; rdy = 1'b1;
        tick();
        ack = 1'b0; dok = 1'b0; rdy = 1'b0;
        tick();
        chk("stray_no_rd", if0.ba_rd, 0);
        cs = 4'b1111;
        #1;
        chk("stray_ok0", if0.slot_ok, 0);
        chk("stray_ok1", if1.slot_ok, 0);
        chk("stray_data", if0.slot_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
